fg_cfg_regbank: RTL and testbench

Parametrised configuration register bank for the function generator. It accepts byte-wide writes from the pad interface via an asynchronous write strobe, synchronises that strobe, and writes exactly once per strobe rising edge. Writes land in a shadow bank; the active bank that drives the function-generator core is updated atomically on a commit pulse. It replaces the fixed 8×8-bit level-triggered register block in the top level.

---
 rtl/fg_cfg_pkg.sv | 13 +
 rtl/fg_sync_edge.sv | 30 +++
 rtl/fg_cfg_regbank.sv | 159 +++++++++++++++
 tb/tb_fg_cfg_regbank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fg_cfg_pkg.sv
// Shared constants and bus-layout helper for the function-generator configuration bank.
package fg_cfg_pkg;

    localparam int FG_DATA_W      = 8;
    localparam int FG_NUM_REGS    = 8;
    localparam int FG_SYNC_STAGES = 2;

    // Register 0 sits in the MSBs of the flattened bus, the last register in the LSBs.
    function automatic int reg_offset(input int idx, input int num_regs, input int data_w);
        return (num_regs - 1 - idx) * data_w;
    endfunction

endpackage

// File: rtl/fg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe followed by a rising-edge detector.
module fg_sync_edge
    import fg_cfg_pkg::*;
#(
    parameter int STAGES = FG_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_i};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level_o = sync_reg[STAGES-1];
    assign rise_o  = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/fg_cfg_regbank.sv
// Configuration register bank with synchronised pad writes and optional double buffering.
// Define FG_CFG_SHADOW_EN to build the shadow bank with commit; otherwise writes hit the active bank.
module fg_cfg_regbank
    import fg_cfg_pkg::*;
#(
    parameter  int DATA_W      = FG_DATA_W,
    parameter  int NUM_REGS    = FG_NUM_REGS,
    parameter  int SYNC_STAGES = FG_SYNC_STAGES,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_async_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     commit_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic [NUM_REGS*DATA_W-1:0] cr_bus_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     wr_ack_o,
    output logic                     pending_o,
    output logic                     err_o
);

    logic                wr_level;
    logic                wr_rise;
    logic                wr_fire;
    logic                wr_addr_ok;
    logic                rd_addr_ok;
    logic                wr_accept;
    logic                wr_reject;
    logic [NUM_REGS-1:0] wr_sel;

    logic [DATA_W-1:0]   active_reg [NUM_REGS];
    logic                ack_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [DATA_W-1:0]   rd_data_next;

    fg_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (wr_async_i),
        .level_o (wr_level),
        .rise_o  (wr_rise)
    );

    assign wr_fire = wr_rise & wr_level;

    // With a power-of-two register count every encodable address is valid.
    generate
        if (NUM_REGS == (1 << ADDR_W)) begin : g_addr_full
            assign wr_addr_ok = 1'b1;
            assign rd_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign wr_addr_ok = (addr_i    < ADDR_W'(NUM_REGS));
            assign rd_addr_ok = (rd_addr_i < ADDR_W'(NUM_REGS));
        end
    endgenerate

    assign wr_accept = wr_fire &  wr_addr_ok;
    assign wr_reject = wr_fire & ~wr_addr_ok;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign wr_sel[gi] = wr_accept && (addr_i == ADDR_W'(gi));
        end
    endgenerate

`ifdef FG_CFG_SHADOW_EN
    logic [DATA_W-1:0] shadow_reg [NUM_REGS];
    logic              pending_reg;
    logic              commit_fire;

    assign commit_fire = commit_i & pending_reg;

    // Non-blocking update means a commit on the write edge copies the pre-write shadow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            pending_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    shadow_reg[i] <= data_i;
                end
                if (commit_fire) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end
            if (wr_accept) begin
                pending_reg <= 1'b1;
            end else if (commit_fire) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending_o = pending_reg;
`else
    logic unused_commit;

    assign unused_commit = commit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    active_reg[i] <= data_i;
                end
            end
        end
    end

    assign pending_o = 1'b0;
`endif

    always_comb begin
        rd_data_next = '0;
        if (rd_addr_ok) begin
            rd_data_next = active_reg[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            ack_reg     <= wr_accept;
            rd_data_reg <= rd_data_next;
            if (wr_reject) begin
                err_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bus
            localparam int OFS = reg_offset(gi, NUM_REGS, DATA_W);
            assign cr_bus_o[OFS +: DATA_W] = active_reg[gi];
        end
    endgenerate

    assign wr_ack_o  = ack_reg;
    assign err_o     = err_reg;
    assign rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_fg_cfg_regbank.sv
// Scoreboard bench for fg_cfg_regbank with six registers; expectations follow FG_CFG_SHADOW_EN.
module tb_fg_cfg_regbank;

    localparam int DW = 8;
    localparam int NR = 6;
    localparam int AW = 3;
`ifdef FG_CFG_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    localparam logic [47:0] CR1 = 48'h0000_00A5_0000;
    localparam logic [47:0] CR2 = 48'h0000_00A5_5A00;
    localparam logic [47:0] CR3 = 48'h1100_00A5_5A00;
    localparam logic [47:0] CR4 = 48'h2200_00A5_5A00;
    localparam logic [47:0] CR5 = 48'h0000_0000_0077;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  data = '0;
    logic           commit = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0] cr_bus;
    logic [DW-1:0]  rd_data;
    logic           wr_ack;
    logic           pending;
    logic           err;

    logic           probe_req = 1'b0;
    int             cyc = 0;
    int             vectors = 0;
    int             miscompares = 0;

    typedef struct {
        string       name;
        logic [47:0] cr;
        logic        pend;
        logic        err;
        logic [7:0]  rd;
        logic        chk_rd;
        int          cyc;
    } exp_t;

    exp_t ack_q[$];
    exp_t probe_q[$];

    fg_cfg_regbank #(
        .DATA_W      (DW),
        .NUM_REGS    (NR),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_async_i (wr),
        .addr_i     (addr),
        .data_i     (data),
        .commit_i   (commit),
        .rd_addr_i  (rd_addr),
        .cr_bus_o   (cr_bus),
        .rd_data_o  (rd_data),
        .wr_ack_o   (wr_ack),
        .pending_o  (pending),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        bit bad;
        vectors++;
        bad = (cr_bus !== e.cr) || (pending !== e.pend) || (err !== e.err) ||
              (e.chk_rd && (rd_data !== e.rd)) || ((e.cyc >= 0) && (cyc != e.cyc));
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got cr=%h pend=%b err=%b rd=%h cyc=%0d, want cr=%h pend=%b err=%b rd=%h(chk=%0b) cyc=%0d",
                     e.name, cr_bus, pending, err, rd_data, cyc, e.cr, e.pend, e.err, e.rd, e.chk_rd, e.cyc);
        end else begin
            $display("ok   %s: cr=%h pend=%b err=%b rd=%h cyc=%0d", e.name, cr_bus, pending, err, rd_data, cyc);
        end
    endtask

    // Monitor: every ack or probe window pops and checks the next expectation.
    always @(negedge clk) begin
        if (wr_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got wr_ack=1 at cyc=%0d, want no ack", cyc);
            end else begin
                check(ack_q.pop_front());
            end
        end
        if (probe_req) begin
            if (probe_q.size() != 0) check(probe_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input string nm, input logic [47:0] cr, input logic p,
                            input logic e, input int c);
        exp_t x;
        x.name = nm; x.cr = cr; x.pend = p; x.err = e; x.rd = '0; x.chk_rd = 1'b0; x.cyc = c;
        ack_q.push_back(x);
    endtask

    task automatic probe(input string nm, input logic [47:0] cr, input logic p, input logic e,
                         input logic [AW-1:0] ra, input logic [7:0] rd_exp);
        exp_t x;
        rd_addr = ra;
        tick(2);
        x.name = nm; x.cr = cr; x.pend = p; x.err = e; x.rd = rd_exp; x.chk_rd = 1'b1; x.cyc = -1;
        probe_q.push_back(x);
        probe_req = 1'b1;
        tick(1);
        probe_req = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [7:0] d, input int hold);
        addr = a;
        data = d;
        wr   = 1'b1;
        tick(hold);
        wr   = 1'b0;
        tick(5);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        probe("in_reset", 48'h0, 1'b0, 1'b0, 3'd0, 8'h00);
        rst = 1'b0;
        tick(1);
        probe("post_reset", 48'h0, 1'b0, 1'b0, 3'd3, 8'h00);

        push_ack("wr_a5_ack", SH ? 48'h0 : CR1, SH, 1'b0, cyc + 3);
        write(3'd3, 8'hA5, 5);
        probe("pre_commit_a5", SH ? 48'h0 : CR1, SH, 1'b0, 3'd3, SH ? 8'h00 : 8'hA5);
        do_commit();
        probe("commit_a5", CR1, 1'b0, 1'b0, 3'd3, 8'hA5);
        probe("rd_out_of_range", CR1, 1'b0, 1'b0, 3'd6, 8'h00);

        push_ack("wr_held_ack", SH ? CR1 : CR2, SH, 1'b0, cyc + 3);
        write(3'd4, 8'h5A, 20);
        probe("held_single_write", SH ? CR1 : CR2, SH, 1'b0, 3'd4, SH ? 8'h00 : 8'h5A);
        do_commit();
        probe("commit_held", CR2, 1'b0, 1'b0, 3'd4, 8'h5A);

        write(3'd7, 8'hFF, 5);
        probe("err_addr7", CR2, 1'b0, 1'b1, 3'd7, 8'h00);

        push_ack("wr_11_ack", SH ? CR2 : CR3, SH, 1'b1, cyc + 3);
        write(3'd0, 8'h11, 5);
        push_ack("wr_22_commit_ack", SH ? CR3 : CR4, SH, 1'b1, cyc + 3);
        addr = 3'd0;
        data = 8'h22;
        wr   = 1'b1;
        tick(2);
        commit = 1'b1;
        tick(1);
        commit = 1'b0;
        tick(2);
        wr = 1'b0;
        tick(5);
        probe("after_collide", SH ? CR3 : CR4, SH, 1'b1, 3'd0, SH ? 8'h11 : 8'h22);
        do_commit();
        probe("commit_22", CR4, 1'b0, 1'b1, 3'd0, 8'h22);

        addr = 3'd5;
        data = 8'h77;
        wr   = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(2);
        probe("reset_mid_strobe", 48'h0, 1'b0, 1'b0, 3'd5, 8'h00);
        rst = 1'b0;
        push_ack("wr_77_after_rst", SH ? 48'h0 : CR5, SH, 1'b0, cyc + 3);
        tick(6);
        wr = 1'b0;
        tick(5);
        probe("post_rst_write", SH ? 48'h0 : CR5, SH, 1'b0, 3'd5, SH ? 8'h00 : 8'h77);
        do_commit();
        probe("commit_77", CR5, 1'b0, 1'b0, 3'd5, 8'h77);

        tick(5);
        while (ack_q.size() != 0) begin
            exp_t x;
            x = ack_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no wr_ack pulse, want one at cyc=%0d", x.name, x.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
